// File: rtl/simd_wb_pkg.sv
// Shared definitions for the SIMD writeback unit: FSM state encodings,
// default widths, FIFO entry width and the perf counter helper.
package simd_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } wb_state_t;

    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DEFAULT_DATA_WIDTH = 32;
    // One FIFO entry carries {addr, data}
    localparam int ENTRY_WIDTH        = DEFAULT_ADDR_WIDTH + DEFAULT_DATA_WIDTH;
    localparam int PERF_WIDTH         = 32;

    // Saturating increment for the performance counters
    function automatic logic [PERF_WIDTH-1:0] sat_inc(input logic [PERF_WIDTH-1:0] v);
        logic [PERF_WIDTH-1:0] one;
        one = {{(PERF_WIDTH-1){1'b0}}, 1'b1};
        return (&v) ? v : (v + one);
    endfunction

endpackage

// File: rtl/simd_wb_fifo.sv
// Synchronous FIFO holding {addr, data} write entries. Head entry is visible
// combinationally; push and pop in the same cycle leave the count unchanged
// and are legal even when full. Pointers wrap naturally (DEPTH is a power of 2).
module simd_wb_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_C   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_pop    = pop && (count_reg != '0);
    assign do_push   = push && ((count_reg != DEPTH_C) || do_pop);
    assign count     = count_reg;
    assign head_data = mem_reg[rd_ptr_reg];

    // Storage array: written on push, no reset so it maps onto plain RAM
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + ONE_C;
                2'b01:   count_reg <= count_reg - ONE_C;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/simd_writeback_unit.sv
// SIMD writeback stage: a delay line aligns each issued element's destination
// with the compute result arriving COMPUTE_LATENCY cycles later, results are
// buffered in a FIFO and written over a valid/ready port. Issue credit counts
// FIFO entries plus in-flight writing elements so nothing is lost under
// backpressure. Reduction partials (wr_en=0) produce no write.
// Optional perf counters are built when SIMD_WB_PERF_EN is defined.
module simd_writeback_unit
    import simd_wb_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
    parameter int COMPUTE_LATENCY = 1,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    input  logic                  issue_wr_en,
    input  logic                  issue_end,
    input  logic [DATA_WIDTH-1:0] cu_data,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [PERF_WIDTH-1:0] perf_wr_count,
    output logic [PERF_WIDTH-1:0] perf_stall_cnt
);

    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W   = CNT_W + 1;

    wb_state_t state_reg;
    wb_state_t state_next;

    logic [COMPUTE_LATENCY-1:0] dl_valid_reg;
    logic [COMPUTE_LATENCY-1:0] dl_wr_en_reg;
    logic [COMPUTE_LATENCY-1:0] dl_end_reg;
    logic [ADDR_WIDTH-1:0]      dl_addr_reg [COMPUTE_LATENCY];
    logic [COMPUTE_LATENCY-1:0] stage_live;

    logic [SUM_W-1:0]   inflight;
    logic [SUM_W-1:0]   credit_used;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_head;

    logic                  issue_accept;
    logic                  tap_valid;
    logic                  tap_wr_en;
    logic                  tap_end;
    logic [ADDR_WIDTH-1:0] tap_addr;
    logic                  push;
    logic                  pop;
    logic                  drain_clear;

    assign issue_accept = issue_valid && issue_ready;

    // Delay line: shifts element metadata so it meets its result at the tap
    always_ff @(posedge clk) begin
        if (reset) begin
            dl_valid_reg <= '0;
            dl_wr_en_reg <= '0;
            dl_end_reg   <= '0;
            for (int i = 0; i < COMPUTE_LATENCY; i++) begin
                dl_addr_reg[i] <= '0;
            end
        end else begin
            dl_valid_reg[0] <= issue_accept;
            dl_wr_en_reg[0] <= issue_wr_en;
            dl_end_reg[0]   <= issue_end;
            dl_addr_reg[0]  <= issue_addr;
            for (int i = 1; i < COMPUTE_LATENCY; i++) begin
                dl_valid_reg[i] <= dl_valid_reg[i-1];
                dl_wr_en_reg[i] <= dl_wr_en_reg[i-1];
                dl_end_reg[i]   <= dl_end_reg[i-1];
                dl_addr_reg[i]  <= dl_addr_reg[i-1];
            end
        end
    end

    // A stage holds a credit only if it will turn into a FIFO push
    generate
        for (genvar gi = 0; gi < COMPUTE_LATENCY; gi++) begin : g_live
            assign stage_live[gi] = dl_valid_reg[gi] & dl_wr_en_reg[gi];
        end
    endgenerate

    // Count of in-flight writing elements
    always_comb begin
        inflight = '0;
        for (int i = 0; i < COMPUTE_LATENCY; i++) begin
            inflight = inflight + SUM_W'(stage_live[i]);
        end
    end

    assign tap_valid = dl_valid_reg[COMPUTE_LATENCY-1];
    assign tap_wr_en = dl_wr_en_reg[COMPUTE_LATENCY-1];
    assign tap_end   = dl_end_reg[COMPUTE_LATENCY-1];
    assign tap_addr  = dl_addr_reg[COMPUTE_LATENCY-1];

    // Credit comes purely from registered state; never depends on wr_ready
    assign credit_used = SUM_W'(fifo_count) + inflight;
    assign issue_ready = (credit_used < SUM_W'(FIFO_DEPTH)) && (state_reg != ST_DRAIN);

    assign push     = tap_valid && tap_wr_en;
    assign wr_valid = (fifo_count != '0);
    assign pop      = wr_valid && wr_ready;
    // Outputs forced to zero when idle so stale RAM contents never show
    assign wr_addr  = wr_valid ? fifo_head[ENTRY_W-1:DATA_WIDTH] : '0;
    assign wr_data  = wr_valid ? fifo_head[DATA_WIDTH-1:0] : '0;

    simd_wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({tap_addr, cu_data}),
        .pop       (pop),
        .count     (fifo_count),
        .head_data (fifo_head)
    );

    // Drain finishes when the FIFO empties this cycle and nothing is in flight;
    // looking at the pop lets done follow the last write by exactly one cycle
    assign drain_clear = (inflight == '0) &&
                         ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (issue_accept) state_next = ST_ACTIVE;
            ST_ACTIVE: if (tap_valid && tap_end) state_next = ST_DRAIN;
            ST_DRAIN:  if (drain_clear) state_next = ST_DONE;
            ST_DONE:   state_next = issue_accept ? ST_ACTIVE : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign busy = (state_reg != ST_IDLE);
    assign done = (state_reg == ST_DONE);

`ifdef SIMD_WB_PERF_EN
    logic [PERF_WIDTH-1:0] perf_wr_count_reg;
    logic [PERF_WIDTH-1:0] perf_stall_cnt_reg;

    // Saturating counters of accepted writes and stalled write cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_wr_count_reg  <= '0;
            perf_stall_cnt_reg <= '0;
        end else begin
            if (pop) begin
                perf_wr_count_reg <= sat_inc(perf_wr_count_reg);
            end
            if (wr_valid && !wr_ready) begin
                perf_stall_cnt_reg <= sat_inc(perf_stall_cnt_reg);
            end
        end
    end

    assign perf_wr_count  = perf_wr_count_reg;
    assign perf_stall_cnt = perf_stall_cnt_reg;
`else
    assign perf_wr_count  = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_simd_writeback_unit.sv
// Testbench for simd_writeback_unit: a default instance (latency 1) driven by
// scenario tasks with a queue-based scoreboard, plus a latency-3 instance.
module tb_simd_writeback_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [15:0] issue_addr = '0;
    logic        issue_wr_en = 1'b0;
    logic        issue_end = 1'b0;
    logic [31:0] issue_data = '0;
    logic [31:0] cu_data;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] perf_wr_count;
    logic [31:0] perf_stall_cnt;

    logic        issue_valid3 = 1'b0;
    logic        issue_ready3;
    logic [15:0] issue_addr3 = '0;
    logic        issue_end3 = 1'b0;
    logic [31:0] issue_data3 = '0;
    logic [31:0] cu_data3;
    logic        wr_valid3;
    logic [15:0] wr_addr3;
    logic [31:0] wr_data3;
    logic        busy3;
    logic        done3;
    logic [31:0] perf_wr_count3;
    logic [31:0] perf_stall_cnt3;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_seen = 0;
    int done_seen = 0;
    int last_wr_cyc = -1;
    int first_wr_cyc = -1;
    int exp_pushed = 0;
    logic        rand_ready = 1'b0;
    logic        stall_prev = 1'b0;
    logic [47:0] stall_word = '0;
    logic [47:0] exp_q [$];

    logic [31:0] pipe1 = '0;
    logic [31:0] pipe3 [3];

    always #5 clk = ~clk;

    simd_writeback_unit #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .COMPUTE_LATENCY(1), .FIFO_DEPTH(4)
    ) u_dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_addr(issue_addr),
        .issue_wr_en(issue_wr_en), .issue_end(issue_end), .cu_data(cu_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done),
        .perf_wr_count(perf_wr_count), .perf_stall_cnt(perf_stall_cnt)
    );

    simd_writeback_unit #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .COMPUTE_LATENCY(3), .FIFO_DEPTH(4)
    ) u_dut3 (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid3), .issue_ready(issue_ready3), .issue_addr(issue_addr3),
        .issue_wr_en(1'b1), .issue_end(issue_end3), .cu_data(cu_data3),
        .wr_valid(wr_valid3), .wr_ready(1'b1), .wr_addr(wr_addr3), .wr_data(wr_data3),
        .busy(busy3), .done(done3),
        .perf_wr_count(perf_wr_count3), .perf_stall_cnt(perf_stall_cnt3)
    );

    // Behavioural compute units: result appears COMPUTE_LATENCY cycles after issue
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        pipe1    <= issue_data;
        pipe3[0] <= issue_data3;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign cu_data  = pipe1;
    assign cu_data3 = pipe3[2];

    // Random scratchpad backpressure when enabled
    always @(posedge clk) begin
        #1;
        if (rand_ready) wr_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard: every accepted write must match the oldest expected entry
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!wr_valid || {wr_addr, wr_data} !== stall_word) begin
                    errors++;
                    $display("FAIL hold_stable: got valid=%b %h_%h required valid=1 %h_%h",
                             wr_valid, wr_addr, wr_data, stall_word[47:32], stall_word[31:0]);
                end
            end
            stall_prev = wr_valid && !wr_ready;
            stall_word = {wr_addr, wr_data};
            if (wr_valid && wr_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got %h_%h required no write", wr_addr, wr_data);
                end else begin
                    logic [47:0] e;
                    e = exp_q.pop_front();
                    if ({wr_addr, wr_data} !== e) begin
                        errors++;
                        $display("FAIL write_data: got %h_%h required %h_%h",
                                 wr_addr, wr_data, e[47:32], e[31:0]);
                    end
                end
                $display("cycle %0d write addr=%h data=%h", cyc, wr_addr, wr_data);
                wr_seen++;
                last_wr_cyc = cyc;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
            end
            if (done) done_seen++;
        end
    end

    // Present one element for one cycle; reports whether it was accepted
    task automatic drive_elem(input logic [15:0] a, input logic we, input logic e,
                              input logic [31:0] d, output logic acc);
        issue_valid = 1'b1;
        issue_addr  = a;
        issue_wr_en = we;
        issue_end   = e;
        issue_data  = d;
        acc = issue_ready;
        if (acc && we) begin
            exp_q.push_back({a, d});
            exp_pushed++;
        end
        @(posedge clk); #1;
        issue_valid = 1'b0;
        issue_end   = 1'b0;
    endtask

    // Retry an element until accepted (bounded)
    task automatic send_elem(input logic [15:0] a, input logic we, input logic e,
                             input logic [31:0] d);
        logic acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 100) begin
            drive_elem(a, we, e, d, acc);
            tries++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: addr %h issue_ready=%b required 1", a, issue_ready);
        end
    endtask

    // Wait for the done pulse (bounded); returns its cycle, leaves at next cycle
    task automatic wait_done(output int d_cyc);
        d_cyc = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done) begin
                d_cyc = cyc;
                break;
            end
        end
        checks++;
        if (d_cyc < 0) begin
            errors++;
            $display("FAIL done_timeout: done=0 required pulse");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 5;
        if (wr_valid !== 1'b0) begin errors++; $display("FAIL rst_wr_valid: got %b required 0", wr_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", done); end
        if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_issue_ready: got %b required 1", issue_ready); end
        if (perf_wr_count !== 32'd0 || perf_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rst_perf: got %0d/%0d required 0/0", perf_wr_count, perf_stall_cnt);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        int c0, d_cyc, wr0, dn0;
        wr0 = wr_seen;
        dn0 = done_seen;
        first_wr_cyc = -1;
        c0 = cyc;
        for (int i = 0; i < 8; i++) send_elem(16'h0010 + 16'(i), 1'b1, i == 7, $urandom);
        wait_done(d_cyc);
        checks += 5;
        if (first_wr_cyc !== c0 + 2) begin errors++; $display("FAIL stream_latency: got cycle %0d required %0d", first_wr_cyc, c0 + 2); end
        if (d_cyc !== last_wr_cyc + 1) begin errors++; $display("FAIL stream_done_timing: got cycle %0d required %0d", d_cyc, last_wr_cyc + 1); end
        if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy_after: got %b required 0", busy); end
        if (wr_seen - wr0 !== 8) begin errors++; $display("FAIL stream_count: got %0d required 8", wr_seen - wr0); end
        @(posedge clk); #1;
        if (done_seen - dn0 !== 1) begin errors++; $display("FAIL stream_done_count: got %0d required 1", done_seen - dn0); end
    endtask

    task automatic test_reduction();
        int d_cyc, wr0, dn0;
        wr0 = wr_seen;
        dn0 = done_seen;
        for (int i = 0; i < 4; i++) send_elem(16'h0040, 1'b0, 1'b0, $urandom);
        send_elem(16'h0040, 1'b1, 1'b1, 32'h0000_0064);
        wait_done(d_cyc);
        repeat (3) @(posedge clk);
        #1;
        checks += 3;
        if (wr_seen - wr0 !== 1) begin errors++; $display("FAIL red_writes: got %0d required 1", wr_seen - wr0); end
        if (done_seen - dn0 !== 1) begin errors++; $display("FAIL red_done_count: got %0d required 1", done_seen - dn0); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL red_pending: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int acc_n, d_cyc;
        logic acc;
        logic [31:0] exp_stall, exp_wrc;
        acc_n = 0;
        wr_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive_elem(16'h0080 + 16'(i), 1'b1, 1'b0, $urandom, acc);
            if (acc) acc_n++;
        end
        checks += 2;
        if (acc_n !== 4) begin errors++; $display("FAIL bp_credits: got %0d accepted required 4", acc_n); end
        if (issue_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b required 0", issue_ready); end
        wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_elem(16'h0090 + 16'(i), 1'b1, i == 3, $urandom);
        wait_done(d_cyc);
        @(posedge clk); #1;
`ifdef SIMD_WB_PERF_EN
        exp_stall = 32'd10;
        exp_wrc   = 32'(exp_pushed);
`else
        exp_stall = 32'd0;
        exp_wrc   = 32'd0;
`endif
        checks += 3;
        if (perf_stall_cnt !== exp_stall) begin errors++; $display("FAIL bp_perf_stall: got %0d required %0d", perf_stall_cnt, exp_stall); end
        if (perf_wr_count !== exp_wrc) begin errors++; $display("FAIL bp_perf_writes: got %0d required %0d", perf_wr_count, exp_wrc); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_pending: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int d_cyc;
        logic we;
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            we = 1'($urandom_range(0, 1));
            send_elem(16'h0100 + 16'(i), we, i == 29, $urandom);
        end
        rand_ready = 1'b0;
        @(posedge clk); #2;
        wr_ready = 1'b1;
        wait_done(d_cyc);
        @(posedge clk); #1;
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_pending: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_reset_drain();
        int wr0, dn0;
        wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_elem(16'h00a0 + 16'(i), 1'b1, i == 2, $urandom);
        @(posedge clk); #1;
        checks += 3;
        if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy: got %b required 1", busy); end
        if (wr_valid !== 1'b1) begin errors++; $display("FAIL drain_valid: got %b required 1", wr_valid); end
        if (issue_ready !== 1'b0) begin errors++; $display("FAIL drain_ready: got %b required 0", issue_ready); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks += 5;
        if (wr_valid !== 1'b0) begin errors++; $display("FAIL rd_wr_valid: got %b required 0", wr_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy: got %b required 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rd_done: got %b required 0", done); end
        if (issue_ready !== 1'b1) begin errors++; $display("FAIL rd_issue_ready: got %b required 1", issue_ready); end
        if (perf_wr_count !== 32'd0 || perf_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rd_perf: got %0d/%0d required 0/0", perf_wr_count, perf_stall_cnt);
        end
        reset = 1'b0;
        exp_q.delete();
        wr_ready = 1'b1;
        wr0 = wr_seen;
        dn0 = done_seen;
        repeat (6) @(posedge clk);
        #1;
        checks += 2;
        if (wr_seen !== wr0) begin errors++; $display("FAIL rd_no_write: got %0d writes required 0", wr_seen - wr0); end
        if (done_seen !== dn0) begin errors++; $display("FAIL rd_no_done: got %0d pulses required 0", done_seen - dn0); end
    endtask

    task automatic test_latency3();
        int c0, n, first, dn;
        logic [31:0] d [4];
        n = 0;
        first = -1;
        dn = 0;
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        c0 = cyc;
        for (int k = 0; k < 30; k++) begin
            if (k < 4) begin
                issue_valid3 = 1'b1;
                issue_addr3  = 16'h0020 + 16'(k);
                issue_data3  = d[k];
                issue_end3   = (k == 3);
                checks++;
                if (issue_ready3 !== 1'b1) begin errors++; $display("FAIL l3_ready: elem %0d got %b required 1", k, issue_ready3); end
            end else begin
                issue_valid3 = 1'b0;
                issue_end3   = 1'b0;
            end
            @(negedge clk);
            if (wr_valid3) begin
                checks++;
                $display("cycle %0d l3 write addr=%h data=%h", cyc, wr_addr3, wr_data3);
                if (n > 3) begin
                    errors++;
                    $display("FAIL l3_extra: got %h_%h required no write", wr_addr3, wr_data3);
                end else if ({wr_addr3, wr_data3} !== {16'h0020 + 16'(n), d[n]}) begin
                    errors++;
                    $display("FAIL l3_pair: got %h_%h required %h_%h", wr_addr3, wr_data3, 16'h0020 + 16'(n), d[n]);
                end
                if (first < 0) first = cyc;
                n++;
            end
            if (done3) dn++;
            @(posedge clk); #1;
        end
        checks += 3;
        if (first !== c0 + 4) begin errors++; $display("FAIL l3_latency: got cycle %0d required %0d", first, c0 + 4); end
        if (n !== 4) begin errors++; $display("FAIL l3_count: got %0d required 4", n); end
        if (dn !== 1) begin errors++; $display("FAIL l3_done: got %0d required 1", dn); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_reduction();
        test_backpressure();
        test_back_to_back();
        test_reset_drain();
        test_latency3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
